jpu_timer_multi: RTL and testbench
==================================

# jpu_timer_multi

Parametrised multi-channel programmable timer for the jpu core, generalising the single fixed-period system tick into NUM_CH independent down-counters. Each channel has its own period, periodic or one-shot mode, and maskable interrupt. Channels are programmed through a simple single-cycle register port. The combined interrupt feeds the CP0 interrupt input.

## Interface
- NUM_CH, 4: number of timer channels, 1..16.
- WIDTH, 32: counter and period width, 8..32.
- PRESCALE, 16'd100: tick divider, in clock cycles per tick; only used when the prescaler is compiled in.
- clk  in  1: system clock.
- rst_n  in  1: reset, asynchronous, active-low.
- wr_en  in  1: register write strobe, one cycle.
- rd_en  in  1: register read strobe, one cycle.
- addr  in  $clog2(NUM_CH)+2: word address; addr[1:0] selects the register, upper bits select the channel.
- wdata  in  32: write data.
- rdata  out  32: read data, registered.
- rd_valid  out  1: rdata is valid; pulses one cycle after rd_en.
- irq_vec  out  NUM_CH: per-channel pending AND irq_en.
- irq  out  1: OR-reduction of irq_vec.

## Operation
- Per-channel registers, selected by addr[1:0]:
  - 0 CTRL: bit0 en, bit1 periodic (1) / one-shot (0), bit2 irq_en.
  - 1 PERIOD: WIDTH bits, zero-extended on read.
  - 2 COUNT: read-only; writes are ignored.
  - 3 STATUS: bit0 pending; write 1 to clear.
- A channel address at or above NUM_CH reads 0; writes to it are ignored.
- Enable load: a CTRL write that moves en from 0 to 1 loads COUNT from PERIOD in the same write cycle.
- Tick behaviour, per enabled channel:
  - COUNT != 0: COUNT decrements.
  - COUNT == 0: pending is set.
  - Periodic: COUNT reloads from PERIOD on the same tick.
  - One-shot: en clears and COUNT holds 0.
- Expiry interval is PERIOD+1 ticks. PERIOD=0 in periodic mode sets pending on every tick.
- A PERIOD write while running takes effect at the next reload only.
- A CTRL write with en=0 freezes COUNT. Re-enabling reloads it.
- Simultaneous pending set (expiry) and W1C clear in the same cycle: set wins.
- Writing CTRL with en 1 to 1: mode and irq_en update, COUNT is not reloaded.
- irq and irq_vec are combinational from the pending and irq_en registers. No pulse stretching.
- Read and write in the same cycle to the same register: the read returns the pre-write value.

## Timing
- Reset: all CTRL/PERIOD/COUNT/STATUS = 0, prescaler counter = 0, rdata = 0, rd_valid = 0, irq = 0, irq_vec = 0.
- Reset asserted mid-count clears state immediately (asynchronous). The first tick comes a full prescale interval after rst_n deasserts.
- Writes take effect at the clock edge of wr_en.
- Reads: rdata and rd_valid are valid the cycle after rd_en. rdata holds until the next read.
- Pending is set on the edge of the expiry tick. irq asserts in the following cycle.
- Counter arithmetic is WIDTH-bit unsigned. Decrement from 0 never occurs, so there is no wrap.

## Configuration
- JPU_TIMER_PRESCALE_EN defined:
  - A shared counter counts 0..PRESCALE-1 and emits a one-cycle tick at wrap.
  - All channels advance only on that tick.
- Undefined:
  - Tick is tied high, so every clock is a tick.
  - PRESCALE is unused.

## Structure
- The jpu package holds:
  - Register offset constants TMR_CTRL, TMR_PERIOD, TMR_COUNT, TMR_STATUS.
  - The packed typedef tmr_ctrl_s {irq_en, periodic, en}.
  - The default JPU_TIMER_PRESCALE constant.
- Sub-module jpu_timer_ch, instantiated NUM_CH times in a generate loop:
  - Inputs: tick, write strobes.
  - Contents: COUNT, PERIOD, CTRL, pending.
- The top level holds address decode, the read mux/register, the prescaler and irq reduction.

## Test plan
- Macro undefined, ch0 PERIOD=3, CTRL=0b111 -> pending first set 4 cycles after the CTRL write edge, then every 4 cycles; irq high after the first expiry until a STATUS write of 1.
- One-shot, ch1 PERIOD=5, CTRL=0b101 -> single expiry after 6 ticks; CTRL reads 0b100; COUNT reads 0; no further pending.
- Prescaler on, PRESCALE=100, ch2 PERIOD=0 periodic -> pending sets every 100 cycles.
- STATUS W1C issued on the same cycle as a periodic expiry -> pending stays 1.
- PERIOD rewritten from 10 to 2 mid-count -> the current interval completes at 11 ticks, then 3-tick intervals follow.
- rst_n pulsed low mid-count with irq high -> all outputs 0 asynchronously; COUNT reads 0 after release; reads of channel NUM_CH return 0 with rd_valid set.

Source files
------------

// File: rtl/jpu_timer_multi_pkg.sv
// Shared constants and types for the jpu multi-channel timer.
// The prescaler is compiled in with JPU_TIMER_PRESCALE_EN (see jpu_timer_multi.sv).
package jpu_timer_multi_pkg;

    localparam logic [1:0] TMR_CTRL   = 2'd0;
    localparam logic [1:0] TMR_PERIOD = 2'd1;
    localparam logic [1:0] TMR_COUNT  = 2'd2;
    localparam logic [1:0] TMR_STATUS = 2'd3;

    localparam logic [15:0] JPU_TIMER_PRESCALE = 16'd100;

    typedef struct packed {
        logic irq_en;
        logic periodic;
        logic en;
    } tmr_ctrl_s;

endpackage

// File: rtl/jpu_timer_ch.sv
// One timer channel: CTRL/PERIOD/COUNT/pending state and the per-tick
// decrement / reload / one-shot stop behaviour.
module jpu_timer_ch
    import jpu_timer_multi_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             wr_ctrl,
    input  logic             wr_period,
    input  logic             wr_status,
    input  logic [WIDTH-1:0] wdata,
    output logic [2:0]       ctrl,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] count,
    output logic             pending
);

    tmr_ctrl_s        ctrl_q, ctrl_d, wr_val;
    logic [WIDTH-1:0] count_d;
    logic             pending_d;
    logic             load, stop, adv, expire, periodic_eff;

    assign wr_val = tmr_ctrl_s'(wdata[2:0]);

    // A 0->1 enable loads COUNT; an en=0 write freezes it for this edge.
    assign load         = wr_ctrl & wr_val.en & ~ctrl_q.en;
    assign stop         = wr_ctrl & ~wr_val.en;
    assign adv          = tick & ctrl_q.en & ~stop;
    assign expire       = adv & (count == '0);
    assign periodic_eff = wr_ctrl ? wr_val.periodic : ctrl_q.periodic;

    always_comb begin
        ctrl_d    = wr_ctrl ? wr_val : ctrl_q;
        count_d   = count;
        pending_d = pending;
        if (load)
            count_d = period;
        else if (adv) begin
            if (count != '0)
                count_d = count - 1'b1;
            else if (periodic_eff)
                count_d = period;
        end
        if (expire && !periodic_eff)
            ctrl_d.en = 1'b0;
        // Expiry beats a same-cycle W1C.
        if (expire)
            pending_d = 1'b1;
        else if (wr_status && wdata[0])
            pending_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q  <= '0;
            period  <= '0;
            count   <= '0;
            pending <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            count   <= count_d;
            pending <= pending_d;
            if (wr_period)
                period <= wdata;
        end
    end

    assign ctrl = ctrl_q;

endmodule

// File: rtl/jpu_timer_multi.sv
// NUM_CH-channel programmable timer: address decode, registered read port,
// shared tick source and irq reduction. `define JPU_TIMER_PRESCALE_EN to
// divide the tick by PRESCALE; otherwise every clock is a tick.
module jpu_timer_multi
    import jpu_timer_multi_pkg::*;
#(
    parameter int          NUM_CH   = 4,
    parameter int          WIDTH    = 32,
    parameter logic [15:0] PRESCALE = JPU_TIMER_PRESCALE
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic                      rd_en,
    input  logic [$clog2(NUM_CH)+1:0] addr,
    input  logic [31:0]               wdata,
    output logic [31:0]               rdata,
    output logic                      rd_valid,
    output logic [NUM_CH-1:0]         irq_vec,
    output logic                      irq
);

    localparam int AW = $clog2(NUM_CH) + 2;
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [CW-1:0]                  ch_sel;
    logic                           ch_ok;
    logic [1:0]                     reg_sel;
    logic                           tick;
    logic [NUM_CH-1:0][2:0]         ctrl_a;
    logic [NUM_CH-1:0][WIDTH-1:0]   period_a, count_a;
    logic [NUM_CH-1:0]              pend_a, irq_en_a;
    logic [NUM_CH-1:0]              wr_ctrl, wr_period, wr_status;
    logic [31:0]                    rd_word;
    logic                           vld_pipe;

    assign reg_sel = addr[1:0];

    generate
        if (NUM_CH > 1) begin : g_sel
            assign ch_sel = addr[AW-1:2];
        end else begin : g_sel1
            assign ch_sel = '0;
        end
    endgenerate

    // Channel fields wider than NUM_CH address nothing.
    assign ch_ok = 32'(ch_sel) < NUM_CH;

`ifdef JPU_TIMER_PRESCALE_EN
    logic [15:0] pre_cnt;

    assign tick = (pre_cnt == PRESCALE - 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pre_cnt <= '0;
        else
            pre_cnt <= tick ? '0 : pre_cnt + 16'd1;
    end
`else
    logic unused_prescale;

    assign unused_prescale = ^PRESCALE;
    assign tick            = 1'b1;
`endif

    genvar i;
    generate
        for (i = 0; i < NUM_CH; i++) begin : g_ch
            logic sel;

            assign sel          = wr_en & ch_ok & (ch_sel == CW'(i));
            assign wr_ctrl[i]   = sel & (reg_sel == TMR_CTRL);
            assign wr_period[i] = sel & (reg_sel == TMR_PERIOD);
            assign wr_status[i] = sel & (reg_sel == TMR_STATUS);
            assign irq_en_a[i]  = ctrl_a[i][2];

            jpu_timer_ch #(.WIDTH(WIDTH)) u_ch (
                .clk       (clk),
                .rst_n     (rst_n),
                .tick      (tick),
                .wr_ctrl   (wr_ctrl[i]),
                .wr_period (wr_period[i]),
                .wr_status (wr_status[i]),
                .wdata     (wdata[WIDTH-1:0]),
                .ctrl      (ctrl_a[i]),
                .period    (period_a[i]),
                .count     (count_a[i]),
                .pending   (pend_a[i])
            );
        end
    endgenerate

    // Registers are sampled before the same-edge write lands.
    always_comb begin
        rd_word = '0;
        if (ch_ok) begin
            case (reg_sel)
                TMR_CTRL:   rd_word[2:0]       = ctrl_a[ch_sel];
                TMR_PERIOD: rd_word[WIDTH-1:0] = period_a[ch_sel];
                TMR_COUNT:  rd_word[WIDTH-1:0] = count_a[ch_sel];
                default:    rd_word[0]         = pend_a[ch_sel];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata    <= '0;
            vld_pipe <= 1'b0;
        end else begin
            vld_pipe <= rd_en;
            if (rd_en)
                rdata <= rd_word;
        end
    end

    assign rd_valid = vld_pipe;
    assign irq_vec  = pend_a & irq_en_a;
    assign irq      = |irq_vec;

endmodule

// File: tb/tb_jpu_timer_multi.sv
// Directed bench for jpu_timer_multi with NUM_CH=3 so that channel 3 is an
// unmapped address. Inputs change on negedge; outputs are sampled on negedge.
module tb_jpu_timer_multi;

    localparam int NUM_CH = 3;
    localparam int AW     = $clog2(NUM_CH) + 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0;
    logic              rd_en = 1'b0;
    logic [AW-1:0]     addr = '0;
    logic [31:0]       wdata = '0;
    logic [31:0]       rdata;
    logic              rd_valid;
    logic [NUM_CH-1:0] irq_vec;
    logic              irq;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    jpu_timer_multi #(.NUM_CH(NUM_CH), .WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .rd_valid (rd_valid),
        .irq_vec  (irq_vec),
        .irq      (irq)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Called at a negedge; the access lands on the next posedge and the task
    // returns at the negedge after it.
    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
        wr_en = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [AW-1:0] a, input logic [31:0] exp);
        rd_en = 1'b1; addr = a;
        @(negedge clk);
        rd_en = 1'b0;
        chk({tag, "_vld"}, 32'(rd_valid), 32'd1);
        chk(tag, rdata, exp);
    endtask

    task automatic step_irq(input string tag, input int n, input logic exp);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk(tag, 32'(irq), 32'(exp));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_irq_vec", 32'(irq_vec), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef JPU_TIMER_PRESCALE_EN
        begin
            int n;
            wr(4'd9, 32'd0);
            wr(4'd8, 32'd7);
            n = 0;
            while (!irq && n < 300) begin
                @(negedge clk);
                n++;
            end
            chk("pre_first", 32'(irq), 32'd1);
            wr(4'd11, 32'd1);
            n = 1;
            while (!irq && n < 300) begin
                @(negedge clk);
                n++;
            end
            chk("pre_interval", 32'(n), 32'd100);
        end
`else
        // ch0 periodic, PERIOD=3: expiries 4 edges apart from the CTRL edge.
        wr(4'd1, 32'd3);
        wr(4'd0, 32'd7);
        step_irq("p_pre", 3, 1'b0);
        step_irq("p_exp1", 1, 1'b1);
        chk("p_vec", 32'(irq_vec), 32'b001);
        wr(4'd3, 32'd1);
        chk("p_clr", 32'(irq), 32'd0);
        step_irq("p_mid", 2, 1'b0);
        step_irq("p_exp2", 1, 1'b1);
        wr(4'd3, 32'd1);
        chk("p_clr2", 32'(irq), 32'd0);
        step_irq("p_mid2", 2, 1'b0);
        wr(4'd3, 32'd1);
        chk("w1c_vs_set", 32'(irq), 32'd1);
        wr(4'd0, 32'd0);
        wr(4'd3, 32'd1);
        step_irq("p_off", 8, 1'b0);

        // ch1 one-shot, PERIOD=5: single expiry 6 ticks after enabling.
        wr(4'd5, 32'd5);
        wr(4'd4, 32'd5);
        step_irq("os_pre", 5, 1'b0);
        step_irq("os_exp", 1, 1'b1);
        chk("os_vec", 32'(irq_vec), 32'b010);
        rd("os_ctrl", 4'd4, 32'd4);
        rd("os_count", 4'd6, 32'd0);
        wr(4'd7, 32'd1);
        step_irq("os_quiet", 10, 1'b0);
        rd("os_status", 4'd7, 32'd0);

        // ch2 PERIOD 10 -> 2 mid-count: 11-tick interval, then 3-tick.
        wr(4'd9, 32'd10);
        wr(4'd8, 32'd7);
        @(negedge clk);
        @(negedge clk);
        wr(4'd9, 32'd2);
        step_irq("pr_pre", 7, 1'b0);
        step_irq("pr_exp11", 1, 1'b1);
        chk("pr_vec", 32'(irq_vec), 32'b100);
        wr(4'd11, 32'd1);
        chk("pr_clr", 32'(irq), 32'd0);
        step_irq("pr_mid", 1, 1'b0);
        step_irq("pr_exp3a", 1, 1'b1);
        wr(4'd11, 32'd1);
        step_irq("pr_mid2", 1, 1'b0);
        step_irq("pr_exp3b", 1, 1'b1);

        // Asynchronous reset while irq is high and rdata is nonzero.
        rd("pre_rst_rd", 4'd9, 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_irq", 32'(irq), 32'd0);
        chk("arst_vec", 32'(irq_vec), 32'd0);
        chk("arst_rdata", rdata, 32'd0);
        chk("arst_vld", 32'(rd_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd("post_count", 4'd10, 32'd0);
        rd("post_ctrl", 4'd8, 32'd0);
        wr(4'd12, 32'd7);
        rd("unmapped", 4'd12, 32'd0);
        wr(4'd2, 32'd55);
        rd("count_ro", 4'd2, 32'd0);

        // Same-cycle read and write return the old value.
        wr(4'd1, 32'd9);
        rd_en = 1'b1; wr_en = 1'b1; addr = 4'd1; wdata = 32'd20;
        @(negedge clk);
        rd_en = 1'b0; wr_en = 1'b0;
        chk("rw_old", rdata, 32'd9);
        rd("rw_new", 4'd1, 32'd20);
        @(negedge clk);
        chk("rd_valid_drop", 32'(rd_valid), 32'd0);
        chk("rdata_hold", rdata, 32'd20);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
